// File: rtl/count_bcd_converter.sv
// -----------------------------------------------------------------------------
// count_bcd_converter
//   Serial binary-to-BCD converter (shift-add-3 / double-dabble), one bit per
//   clock, sitting between the 10..40 range counter and the digit display
//   driver. Valid/ready handshake on both sides.
//
//   Optional feature macro: BCD_RANGE_FLAG_EN
//     defined   : adds RANGE_LO/RANGE_HI parameters and the range_err output,
//                 flagging counts outside RANGE_LO..RANGE_HI; presented with
//                 bcd_out.
//     undefined : no range_err port, no compare logic.
//
// Ports
//   clk        in   1          clock, all state on posedge
//   rst        in   1          synchronous, active-low reset
//   in_valid   in   1          bin_in is valid
//   in_ready   out  1          converter can accept bin_in (IDLE only)
//   bin_in     in   WIDTH      binary count
//   out_valid  out  1          bcd_out holds a completed conversion
//   out_ready  in   1          consumer takes bcd_out
//   bcd_out    out  4*DIGITS   packed BCD, digit 0 in [3:0]
//   range_err  out  1          (BCD_RANGE_FLAG_EN only) count out of range
// -----------------------------------------------------------------------------
module count_bcd_converter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 3
`ifdef BCD_RANGE_FLAG_EN
    ,
    parameter int unsigned RANGE_LO = 10,
    parameter int unsigned RANGE_HI = 40
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    bin_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd_out
`ifdef BCD_RANGE_FLAG_EN
    ,
    output logic                range_err
`endif
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned TOT_W = BCD_W + WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state;
    // Working register: BCD accumulator in the upper BCD_W bits, binary below.
    logic [TOT_W-1:0]   sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic [BCD_W-1:0]   bcd_adj;
    logic [TOT_W-1:0]   sr_next;

`ifdef BCD_RANGE_FLAG_EN
    // Flag computed at acceptance, held until the result is published.
    logic               range_pend;
    logic               range_hit_c;

    assign range_hit_c = (bin_in < WIDTH'(RANGE_LO)) || (bin_in > WIDTH'(RANGE_HI));
`endif

    // One double-dabble step: add 3 to each digit >= 5 (no inter-digit carry),
    // then shift the whole {bcd, bin} register left by one.
    always_comb begin
        bcd_adj = '0;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (sr[WIDTH + 4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = sr[WIDTH + 4*d +: 4] + 4'd3;
            end else begin
                bcd_adj[4*d +: 4] = sr[WIDTH + 4*d +: 4];
            end
        end
        sr_next = {bcd_adj, sr[WIDTH-1:0]} << 1;
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            bcd_out    <= '0;
`ifdef BCD_RANGE_FLAG_EN
            range_pend <= 1'b0;
            range_err  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        sr         <= {BCD_W'(0), bin_in};
                        bit_cnt    <= CNT_W'(WIDTH);
                        in_ready   <= 1'b0;
                        state      <= S_SHIFT;
`ifdef BCD_RANGE_FLAG_EN
                        range_pend <= range_hit_c;
`endif
                    end else begin
                        in_ready   <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    sr      <= sr_next;
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    // Last shift: publish the finished digits in one step.
                    if (bit_cnt == CNT_W'(1)) begin
                        bcd_out   <= sr_next[TOT_W-1:WIDTH];
                        out_valid <= 1'b1;
                        state     <= S_DONE;
`ifdef BCD_RANGE_FLAG_EN
                        range_err <= range_pend;
`endif
                    end
                end

                S_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_bcd_converter.sv
// -----------------------------------------------------------------------------
// tb_count_bcd_converter
//   Directed and randomized checks of count_bcd_converter against a decimal
//   digit model (divide/modulo by 10). Define BCD_RANGE_FLAG_EN to also check
//   range_err.
// -----------------------------------------------------------------------------
module tb_count_bcd_converter;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIGITS = 3;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    bin_in;
    logic                out_valid;
    logic                out_ready;
    logic [4*DIGITS-1:0] bcd_out;
`ifdef BCD_RANGE_FLAG_EN
    logic                range_err;
`endif

    int unsigned passed = 0;
    int unsigned total  = 0;
    logic [11:0] last_bcd = '0;

    count_bcd_converter #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out)
`ifdef BCD_RANGE_FLAG_EN
        ,
        .range_err (range_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by plain arithmetic.
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One full transaction; hold = DONE cycles with out_ready low,
    // noise = toggle in_valid/bin_in while busy (must be ignored).
    task automatic convert(input int v, input int hold, input bit noise);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid  = 1'b1;
        bin_in    = 8'(v);
        out_ready = 1'b0;
        @(negedge clk);
        check("accept_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        for (int k = 1; k < int'(WIDTH); k++) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                bin_in   = 8'($urandom);
            end
            @(negedge clk);
        end
        check("not_early_valid", 32'(out_valid), 32'd0);
        check("bcd_held_shift", 32'(bcd_out), 32'(last_bcd));
        @(negedge clk);
        check("latency_valid", 32'(out_valid), 32'd1);
        check($sformatf("bcd_%0d", v), 32'(bcd_out), 32'(to_bcd(v)));
`ifdef BCD_RANGE_FLAG_EN
        check($sformatf("range_err_%0d", v), 32'(range_err), 32'((v < 10) || (v > 40)));
`endif
        last_bcd = to_bcd(v);
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                bin_in   = 8'($urandom);
            end
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_bcd", 32'(bcd_out), 32'(last_bcd));
            check("bp_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid_low", 32'(out_valid), 32'd0);
        check("release_idle_ready", 32'(in_ready), 32'd1);
        check("release_bcd_held", 32'(bcd_out), 32'(last_bcd));
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin_in    = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
`ifdef BCD_RANGE_FLAG_EN
        check("rst_range_err", 32'(range_err), 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Directed cases.
        convert(40, 0, 1'b0);
        convert(10, 0, 1'b1);
        convert(39, 0, 1'b1);
        convert(0, 0, 1'b0);
        convert(255, 0, 1'b0);
        convert(25, 6, 1'b1);

        // Reset on the 4th shift edge discards the conversion.
        in_valid = 1'b1;
        bin_in   = 8'd77;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_bcd", 32'(bcd_out), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_release_ready", 32'(in_ready), 32'd1);
        last_bcd = '0;
        repeat (WIDTH + 2) @(negedge clk);
        check("midrst_no_result", 32'(out_valid), 32'd0);
        check("midrst_bcd_still0", 32'(bcd_out), 32'd0);
        convert(33, 0, 1'b0);

        // Range boundaries.
        convert(9, 0, 1'b0);
        convert(41, 1, 1'b0);
        convert(10, 0, 1'b0);
        convert(40, 2, 1'b0);

        // Randomized values and backpressure.
        for (int i = 0; i < 24; i++) begin
            convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
